// File: rtl/hdmi_tx_pkg.sv
// hdmi_tx_pkg: shared constants and types for the HDMI/DVI video transmitter.
//   - TMDS control-period symbols (indexed by the two control bits)
//   - HDMI video guard-band symbols
//   - period_e: what a lane encoder emits in a given cycle
//   - stage_t:  first pipeline stage between timing/input logic and encoders
// Symbol constants are written MSB first; bit 0 leaves the serialiser first.
package hdmi_tx_pkg;

    localparam int NUM_LANES = 3;

    localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_SYM_02 = 10'b1011001100;  // lanes 0 and 2
    localparam logic [9:0] GUARD_SYM_1  = 10'b0100110011;  // lane 1

    typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, ACTIVE} period_e;

    typedef enum logic {ST_SYNC, ST_RUN} in_state_e;

    typedef struct packed {
        period_e                   period;
        logic [NUM_LANES-1:0][1:0] ctrl;
        logic [NUM_LANES-1:0][7:0] data;
        logic                      sof;
        logic                      uf;
    } stage_t;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_SYM_00;
            2'b01:   return CTRL_SYM_01;
            2'b10:   return CTRL_SYM_10;
            default: return CTRL_SYM_11;
        endcase
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// tmds_lane_enc: one TMDS lane. 8b/10b video encoding with running disparity,
// plus control / guard symbol selection driven by the period input.
// Ports:
//   clk, resetn   pixel clock, synchronous active-low reset
//   period        CTRL / PREAMBLE / GUARD / ACTIVE for this cycle
//   data          video byte (used in ACTIVE)
//   ctrl          two control bits (used in CTRL and PREAMBLE)
//   sym           registered 10-bit symbol, bit 0 transmitted first
// Parameters: GUARD_SYM (lane-specific guard band), IDLE_CTRL (control bits
// emitted out of reset).
module tmds_lane_enc
    import hdmi_tx_pkg::*;
#(
    parameter logic [9:0] GUARD_SYM = GUARD_SYM_02,
    parameter logic [1:0] IDLE_CTRL = 2'b00
) (
    input  logic       clk,
    input  logic       resetn,
    input  period_e    period,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    output logic [9:0] sym
);

    logic signed [5:0] disp;      // running disparity (ones minus zeros)
    logic signed [5:0] disp_nxt;
    logic signed [5:0] diff;      // ones minus zeros of q_m[7:0]
    logic [3:0]        n1d, n1q;
    logic              use_xnor;
    logic [8:0]        qm;
    logic [9:0]        enc;

    always_comb begin
        n1d      = ones8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        qm       = '0;
        qm[0]    = data[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ data[i]) : (qm[i-1] ^ data[i]);
        qm[8]    = ~use_xnor;
        n1q      = ones8(qm[7:0]);
        diff     = $signed({1'b0, n1q, 1'b0}) - 6'sd8;

        if ((disp == 6'sd0) || (diff == 6'sd0)) begin
            enc      = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp_nxt = qm[8] ? disp + diff : disp - diff;
        end else if (((disp > 6'sd0) && (diff > 6'sd0)) ||
                     ((disp < 6'sd0) && (diff < 6'sd0))) begin
            // invert to pull the running disparity back towards zero
            enc      = {1'b1, qm[8], ~qm[7:0]};
            disp_nxt = disp - diff + (qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            enc      = {1'b0, qm[8], qm[7:0]};
            disp_nxt = disp + diff - (qm[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sym  <= ctrl_sym(IDLE_CTRL);
            disp <= '0;
        end else begin
            unique case (period)
                ACTIVE: begin
                    sym  <= enc;
                    disp <= disp_nxt;
                end
                GUARD: begin
                    sym  <= GUARD_SYM;
                    disp <= '0;
                end
                default: begin
                    sym  <= ctrl_sym(ctrl);
                    disp <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hdmi_video_tx.sv
// hdmi_video_tx: video timing, AXI-Stream pixel intake with start-of-frame
// resynchronisation, and three TMDS lanes feeding the 10:1 serialisers.
// Ports:
//   clk, resetn                      pixel clock, synchronous active-low reset
//   in_axis_tvalid/tready/tdata/tuser pixel stream, tuser marks SOF
//   out_tmds0..2                     lane symbols, bit 0 transmitted first
//   frame_start                      pulse with the first active symbol
//   underflow                        pulse with each substituted black symbol
// Latency: a position/handshake in cycle n appears on the outputs in n+2.
// Build option: HDMI_TX_GUARD_EN adds video preamble and guard band before
// each active line (HDMI); without it those cycles are plain control (DVI).
module hdmi_video_tx
    import hdmi_tx_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 64,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 192,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_axis_tvalid,
    output logic        in_axis_tready,
    input  logic [23:0] in_axis_tdata,
    input  logic        in_axis_tuser,
    output logic [9:0]  out_tmds0,
    output logic [9:0]  out_tmds1,
    output logic [9:0]  out_tmds2,
    output logic        frame_start,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef HDMI_TX_GUARD_EN
    localparam logic [HW-1:0] PRE_BEG  = HW'(H_TOTAL - 10);
    localparam logic [HW-1:0] PRE_LAST = HW'(H_TOTAL - 3);
    localparam logic [HW-1:0] GRD_BEG  = HW'(H_TOTAL - 2);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
`endif

    // control bits with both syncs deasserted, per lane
    localparam logic [NUM_LANES-1:0][1:0] CTRL_IDLE =
        {2'b00, 2'b00, {~VSYNC_POL, ~HSYNC_POL}};

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    in_state_e     state;
    stage_t        s1;

    logic          at_first, active, hs_on, vs_on, show, uf_now;
    period_e       period;
    logic [NUM_LANES-1:0][1:0] ctrl;
    logic [NUM_LANES-1:0][7:0] pix;
    logic [NUM_LANES-1:0][9:0] sym;
`ifdef HDMI_TX_GUARD_EN
    logic          pre_line;
`endif

    always_comb begin
        at_first = (h == '0) && (v == '0);
        active   = (h < H_ACT) && (v < V_ACT);
        hs_on    = (h >= HS_BEG) && (h <= HS_LAST);
        vs_on    = (v >= VS_BEG) && (v <= VS_LAST);
`ifdef HDMI_TX_GUARD_EN
        // line whose successor is an active line
        pre_line = (v == V_LAST) || (v < V_ACT_M1);
`endif
    end

    // SYNC drops plain beats and parks an SOF beat until (0,0).
    // RUN takes one beat per active pixel but never an SOF past (0,0).
    always_comb begin
        if (state == ST_SYNC)
            in_axis_tready = in_axis_tvalid && (!in_axis_tuser || at_first);
        else
            in_axis_tready = active && !(in_axis_tuser && !at_first);
    end

    always_comb begin
        show   = in_axis_tvalid && in_axis_tready && active &&
                 ((state == ST_RUN) || (at_first && in_axis_tuser));
        uf_now = (state == ST_RUN) && active && !in_axis_tvalid;
        for (int l = 0; l < NUM_LANES; l++)
            pix[l] = show ? in_axis_tdata[8*(NUM_LANES-1-l) +: 8] : 8'h00;
    end

    always_comb begin
        period = active ? ACTIVE : CTRL;
`ifdef HDMI_TX_GUARD_EN
        if (!active && pre_line && (h >= GRD_BEG))
            period = GUARD;
        else if (!active && pre_line && (h >= PRE_BEG) && (h <= PRE_LAST))
            period = PREAMBLE;
`endif
        ctrl    = '0;
        ctrl[0] = {vs_on ? VSYNC_POL : ~VSYNC_POL, hs_on ? HSYNC_POL : ~HSYNC_POL};
        ctrl[1] = (period == PREAMBLE) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            h           <= H_ACT;
            v           <= V_ACT;
            state       <= ST_SYNC;
            s1.period   <= CTRL;
            s1.ctrl     <= CTRL_IDLE;
            s1.data     <= '0;
            s1.sof      <= 1'b0;
            s1.uf       <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            case (state)
                ST_SYNC:
                    if (at_first && in_axis_tvalid && in_axis_tuser)
                        state <= ST_RUN;
                // early SOF (tuser off the first pixel) or first pixel
                // without tuser both lose frame lock
                default:
                    if (active && in_axis_tvalid && (in_axis_tuser != at_first))
                        state <= ST_SYNC;
            endcase

            s1.period   <= period;
            s1.ctrl     <= ctrl;
            s1.data     <= pix;
            s1.sof      <= at_first;
            s1.uf       <= uf_now;
            frame_start <= s1.sof;
            underflow   <= s1.uf;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        tmds_lane_enc #(
            .GUARD_SYM (l == 1 ? GUARD_SYM_1 : GUARD_SYM_02),
            .IDLE_CTRL (CTRL_IDLE[l])
        ) u_enc (
            .clk    (clk),
            .resetn (resetn),
            .period (s1.period),
            .data   (s1.data[l]),
            .ctrl   (s1.ctrl[l]),
            .sym    (sym[l])
        );
    end

    assign out_tmds0 = sym[0];
    assign out_tmds1 = sym[1];
    assign out_tmds2 = sym[2];

endmodule

// File: doc/hdmi_video_tx.md
# hdmi_video_tx

Parametrised HDMI/DVI video transmitter core: generates resolution-independent video timing, pulls pixels from an AXI-Stream source with start-of-frame resynchronisation, and TMDS-encodes three lanes into 10-bit symbols. Its outputs feed the per-lane 10:1 serialisers directly. It sits in the `clk_pixel` domain between the pixel source and the OSER10/ELVDS output stage. It adds HDMI video preamble/guard bands, sync polarity control and underflow handling beyond the fixed-720p DVI path.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 64; H_SYNC, 128; H_BP, 192: horizontal porch and sync widths in pixels; H_BP >= 10
- V_ACTIVE, 720; V_FP, 3; V_SYNC, 5; V_BP, 20: vertical sizes in lines
- HSYNC_POL, 1; VSYNC_POL, 1: asserted sync level (1 = active-high)
- clk  in  1  pixel clock; the only clock
- resetn  in  1  synchronous, active-low reset
- in_axis_tvalid  in  1  pixel valid
- in_axis_tready  out  1  pixel accept
- in_axis_tdata  in  24  [23:16] → lane 0, [15:8] → lane 1, [7:0] → lane 2
- in_axis_tuser  in  1  start of frame; marks the first pixel of a frame
- out_tmds0, out_tmds1, out_tmds2  out  10 each  lane symbols; bit 0 is transmitted first (serialiser D0)
- frame_start  out  1  one-cycle pulse, aligned with the first active symbol of each frame
- underflow  out  1  one-cycle pulse, aligned with each substituted black symbol

## Operation
- Counters: h counts 0..H_TOTAL-1 and v counts 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (likewise V_TOTAL).
  - Line order: active, then FP, then sync, then BP. Frame order is the same.
  - Active pixel when h<H_ACTIVE and v<V_ACTIVE.
  - hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v.
  - Both syncs are driven at their *_POL level when asserted.
- A "pre-active" line is v==V_TOTAL-1 or v<V_ACTIVE-1.
  - Preamble: h in [H_TOTAL-10, H_TOTAL-3] of a pre-active line.
  - Guard: h in {H_TOTAL-2, H_TOTAL-1} of a pre-active line.
- Lane coding by period:
  - Active: TMDS 8b/10b with running disparity.
  - Control: lane 0 carries {vsync, hsync}. Lanes 1 and 2 carry 00, except during preamble, where lane 1 = 01 and lane 2 = 00.
  - Control symbols: 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011.
  - Guard: lanes 0 and 2 = 1011001100, lane 1 = 0100110011.
  - Disparity is cleared to 0 in every non-active cycle.
- Input state machine:
  - SYNC (reset state):
    - tready=1 while tvalid && !tuser, so non-SOF beats are dropped.
    - An SOF beat is held with tready=0 until h==0 && v==0.
    - At h==0 && v==0 the SOF beat is accepted and the state moves to RUN.
    - If no SOF beat is present at that point, the frame outputs black.
  - RUN: tready = active && !(tuser && not first pixel).
    - Early SOF (tuser=1 at any active position other than (0,0)): the beat is not accepted, the rest of the frame outputs black with no underflow pulse, and the state moves to SYNC.
    - First pixel with tuser=0: the pixel is displayed and the state moves to SYNC.
  - Underflow (active pixel with tvalid=0 in RUN): the pixel is output as 0x000000, underflow pulses, and the state stays RUN.
- tready is never asserted in blanking while in RUN.

## Timing
- tready is combinational from state, counters, in_axis_tvalid and in_axis_tuser.
- Latency is 2 cycles. A beat handshaken, or a timing position reached, in cycle n drives out_tmds* in cycle n+2. frame_start and underflow share that alignment.
- Reset (resetn low at a rising edge):
  - Counters go to h=H_ACTIVE, v=V_ACTIVE; state goes to SYNC; disparity goes to 0.
  - frame_start=0 and underflow=0.
  - out_tmds* carry the control symbols for deasserted syncs, e.g. all three = 1101010100 with default polarities.
  - Values take effect from the next cycle.
- Reset mid-frame abandons the frame with no partial symbols. The first frame after reset begins at v=0 after the remaining vertical blanking.

## Configuration
- HDMI_TX_GUARD_EN defined: preamble and guard periods are emitted as above (HDMI mode).
- HDMI_TX_GUARD_EN undefined: those cycles are ordinary control periods with lanes 1 and 2 = 00 (pure DVI), and the H_BP >= 10 constraint is lifted.
- Latency is identical in both cases.

## Structure
- Shared package hdmi_tx_pkg holds:
  - the four control-symbol constants;
  - the guard-band constants;
  - the period enum (CTRL, PREAMBLE, GUARD, ACTIVE).
- Sub-module tmds_lane_enc, instantiated three times. It has a registered output and performs 8b/10b encoding with a disparity register, plus the control/guard muxing selected by the period input.

## Test plan
- Small timing (H 16/2/2/12, V 4/1/1/2), continuous valid stream with SOF: symbol-stream lengths per period match the parameters; lane 0 shows 0010101011 during hsync only; frame_start pulses once per frame.
- Constant pixel 0x101010: decoded lanes return 0x10 and disparity stays bounded within ±8 each line. With HDMI_TX_GUARD_EN, the 8 preamble symbols on lane 1 are 0010101011 and the last 2 blanking symbols are the guard band.
- After reset, source sends 5 non-SOF beats then an SOF frame: the 5 beats are dropped, the SOF pixel appears as the first active symbol 2 cycles after (0,0), and underflow stays 0.
- tvalid low for 3 active pixels mid-line: 3 black symbols and 3 underflow pulses, then data resumes with no pixel loss.
- tuser=1 at pixel (5,1): that beat is not accepted, black to end of frame, and that beat is displayed at (0,0) of the next frame.
- resetn low for 1 cycle mid-line: outputs match the reset values from the following cycle.
